pipe_apx_mul: RTL
=================

# pipe_apx_mul

Parametrised, pipelined, runtime-configurable approximate unsigned multiplier. Splits each WIDTH-bit operand into high and low halves and forms four HALF×HALF quadrant products (HH, HL, LH, LL). Each quadrant is independently exact or approximate per transaction, then the quadrants are shifted and summed. It is the streaming successor to the fixed 8×8 four-quadrant combinational multiplier, adding valid/ready flow control for use in accelerator datapaths.

## Interface
- WIDTH, 8, operand width; even, 8..32; HALF = WIDTH/2
- APX_BITS, 2, low bits cleared in an approximate quadrant product; 0..HALF
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  input accepted when in_valid & in_ready
- a, b  in  WIDTH each  unsigned operands
- mode  in  4  per-quadrant approximate enable: [3]=HH, [2]=HL, [1]=LH, [0]=LL; 1 = approximate
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- prod  out  2*WIDTH  product
- stat_clr  in  1  synchronous clear of error statistics
- err_cnt  out  16  count of results that differ from the exact product
- err_max  out  2*WIDTH  maximum absolute error seen

## Operation
- Quadrants: hh = ah*bh, hl = ah*bl, lh = al*bh, ll = al*bl, each 2*HALF bits. Approximate quadrant = exact quadrant with bits [APX_BITS-1:0] forced to 0.
- Sum: prod = (hh << WIDTH) + ((hl + lh) << HALF) + ll, computed at full 2*WIDTH+1 bits and truncated to 2*WIDTH. The truncation cannot lose bits because result ≤ exact product.
- Stage S1 registers a, b and mode on acceptance. Stage S2 registers the four quadrant products. Stage S3 registers prod (and, under the macro, the exact product).
- Each stage has a valid bit. A stage loads when it is empty or when its contents advance in the same cycle.
- in_ready = ~v1 | (adv into S2). Output advances when out_valid & out_ready.
- Full pipeline holds 3 transactions. Transactions emerge in order, with no drops and no duplicates.
- mode travels with its operands; a mode change never affects transactions already accepted.

## Timing
- Latency: 3 cycles, from accepting edge to out_valid, when unstalled.
- Throughput: 1 per cycle while out_ready = 1.
- in_ready is combinational from out_ready through the stage valids. There is no combinational path from in_valid to in_ready.
- prod is held stable while out_valid & ~out_ready.
- Reset values: all stage valids 0, out_valid 0, prod 0, err_cnt 0, err_max 0. in_ready = 1 immediately after reset.
- Reset mid-operation discards all in-flight transactions with no output.
- When accept and output happen in the same cycle with the pipeline full, the pipe shifts and occupancy is unchanged.

## Configuration
- APXMUL_ERRSTAT_EN defined:
  - S1→S3 also carries the exact product. On each output handshake, a nonzero |exact − prod| increments err_cnt, which saturates at 0xFFFF.
  - err_max updates to the error value when the new error exceeds it.
  - stat_clr zeroes both counters. If stat_clr coincides with a handshake, the clear wins.
- Not defined: no exact-product datapath is built; err_cnt and err_max are tied to 0 and stat_clr is ignored.

## Structure
- Package apx_mul_pkg holds:
  - mode bit index constants (MODE_HH=3, MODE_HL=2, MODE_LH=1, MODE_LL=0)
  - default APX_BITS
  - the stage-valid/handshake typedef shared with other pipelined approximate units
- Sub-module apx_quad_mul(HALF, APX_BITS) implements one HALF×HALF multiplier with an apx enable input. It is instantiated four times in S2.

## Test plan
- WIDTH=8, APX_BITS=2, a=0xFF, b=0xFF, mode=0000 → prod=0xFE01 exactly 3 cycles after accept.
- Same operands, mode=1111 → prod=0xFCE0. Same operands, mode=0001 → prod=0xFE00. With the macro: err_cnt=2, err_max=0x121.
- Streaming: 8 back-to-back transactions (a=i, b=i+1), out_ready=1 → one result per cycle, in order, correct exact values.
- Backpressure: out_ready=0 while 4 transactions are offered → 3 accepted, in_ready=0 on the 4th, prod held. Raising out_ready drains all 4 in order.
- rst_n asserted with 2 in flight → out_valid=0 at once; no stale results after release; counters read 0.
- Macro build: 70000 approximate-error results → err_cnt saturates at 0xFFFF. stat_clr together with an erroneous handshake → err_cnt=0 next cycle.

Source files
------------

// File: rtl/apx_mul_pkg.sv
// Shared constants and types for the pipelined approximate multiplier family.
// Latency: none (package only). Backpressure: not applicable.
package apx_mul_pkg;
    localparam int MODE_HH = 3;
    localparam int MODE_HL = 2;
    localparam int MODE_LH = 1;
    localparam int MODE_LL = 0;

    localparam int APX_BITS_DEF = 2;

    // One bit per pipeline stage, index 0 = first stage.
    typedef logic [2:0] stage_vld_t;
endpackage

// File: rtl/pipe_apx_mul_if.sv
// Operand/result stream bundle for pipe_apx_mul: valid/ready in, valid/ready out.
// Latency: none (wiring). Backpressure: carried by in_ready/out_ready.
interface pipe_apx_mul_if #(parameter int WIDTH = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod;

    modport master (output in_valid, a, b, mode, out_ready,
                    input  in_ready, out_valid, prod);
    modport slave  (input  in_valid, a, b, mode, out_ready,
                    output in_ready, out_valid, prod);
endinterface

// File: rtl/apx_quad_mul.sv
// One HALF x HALF quadrant multiplier; apx clears the low APX_BITS of the product.
// Latency: combinational. Backpressure: none.
module apx_quad_mul #(
    parameter int HALF     = 4,
    parameter int APX_BITS = 2
) (
    input  logic [HALF-1:0]   x,
    input  logic [HALF-1:0]   y,
    input  logic              apx,
    output logic [2*HALF-1:0] p
);
    localparam logic [2*HALF-1:0] KEEP = {2*HALF{1'b1}} << APX_BITS;

    logic [2*HALF-1:0] exact;

    assign exact = (2*HALF)'(x) * (2*HALF)'(y);
    assign p     = apx ? (exact & KEEP) : exact;
endmodule

// File: rtl/pipe_apx_mul.sv
// Pipelined four-quadrant approximate multiplier, 3 stages, valid/ready with full-rate stall propagation.
// Optional error statistics under APXMUL_ERRSTAT_EN; in_ready depends on out_ready, never on in_valid.
module pipe_apx_mul
    import apx_mul_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int APX_BITS = APX_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_apx_mul_if.slave      bus,
    input  logic               stat_clr,
    output logic [15:0]        err_cnt,
    output logic [2*WIDTH-1:0] err_max
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int QW   = 2 * HALF;

    stage_vld_t vld;
    stage_vld_t adv;
    logic       acc;

    logic [WIDTH-1:0] a1, b1;
    logic [3:0]       m1;
    logic [QW-1:0]    q_hh, q_hl, q_lh, q_ll;
    logic [QW-1:0]    hh2, hl2, lh2, ll2;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    prod3;

    // adv[i]: stage i hands its contents on this cycle.
    always_comb begin
        adv    = '0;
        adv[2] = vld[2] & bus.out_ready;
        adv[1] = vld[1] & (~vld[2] | adv[2]);
        adv[0] = vld[0] & (~vld[1] | adv[1]);
    end

    assign bus.in_ready  = ~vld[0] | adv[0];
    assign acc           = bus.in_valid & bus.in_ready;
    assign bus.out_valid = vld[2];
    assign bus.prod      = prod3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= acc    | (vld[0] & ~adv[0]);
            vld[1] <= adv[0] | (vld[1] & ~adv[1]);
            vld[2] <= adv[1] | (vld[2] & ~adv[2]);
        end
    end

    apx_quad_mul #(.HALF(HALF), .APX_BITS(APX_BITS)) u_hh (
        .x(a1[WIDTH-1:HALF]), .y(b1[WIDTH-1:HALF]), .apx(m1[MODE_HH]), .p(q_hh));
    apx_quad_mul #(.HALF(HALF), .APX_BITS(APX_BITS)) u_hl (
        .x(a1[WIDTH-1:HALF]), .y(b1[HALF-1:0]),     .apx(m1[MODE_HL]), .p(q_hl));
    apx_quad_mul #(.HALF(HALF), .APX_BITS(APX_BITS)) u_lh (
        .x(a1[HALF-1:0]),     .y(b1[WIDTH-1:HALF]), .apx(m1[MODE_LH]), .p(q_lh));
    apx_quad_mul #(.HALF(HALF), .APX_BITS(APX_BITS)) u_ll (
        .x(a1[HALF-1:0]),     .y(b1[HALF-1:0]),     .apx(m1[MODE_LL]), .p(q_ll));

    // Approximation only clears bits, so the sum never exceeds the exact product and fits in PW bits.
    assign sum = (PW'(hh2) << WIDTH) + ((PW'(hl2) + PW'(lh2)) << HALF) + PW'(ll2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1    <= '0;
            b1    <= '0;
            m1    <= '0;
            hh2   <= '0;
            hl2   <= '0;
            lh2   <= '0;
            ll2   <= '0;
            prod3 <= '0;
        end else begin
            if (acc) begin
                a1 <= bus.a;
                b1 <= bus.b;
                m1 <= bus.mode;
            end
            if (adv[0]) begin
                hh2 <= q_hh;
                hl2 <= q_hl;
                lh2 <= q_lh;
                ll2 <= q_ll;
            end
            if (adv[1]) begin
                prod3 <= sum;
            end
        end
    end

`ifdef APXMUL_ERRSTAT_EN
    logic [PW-1:0] ex2, ex3, err;

    assign err = ex3 - prod3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex2     <= '0;
            ex3     <= '0;
            err_cnt <= '0;
            err_max <= '0;
        end else begin
            if (adv[0]) ex2 <= PW'(a1) * PW'(b1);
            if (adv[1]) ex3 <= ex2;
            // A clear in the same cycle as an erroneous handshake discards that sample.
            if (stat_clr) begin
                err_cnt <= '0;
                err_max <= '0;
            end else if (adv[2] && err != '0) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err > err_max)       err_max <= err;
            end
        end
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign err_cnt         = '0;
    assign err_max         = '0;
`endif
endmodule
